// File: rtl/swt_pkg.sv
// Shared constants and types for the switch event arbiter.
package swt_pkg;

    localparam int SWT_W            = 8;
    localparam int TICK_DIV_DEFAULT = 100000;

    // IDLE: waiting for a pending request. OFFER: an event is presented.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/switch_event_arbiter_rr_picker.sv
// Round-robin request picker: returns the first set request found when
// searching upward from last+1, wrapping modulo WIDTH. The search covers
// all WIDTH positions, so 'last' itself is the final candidate.
module rr_picker #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int j;

    // Scan from the farthest offset down to the nearest so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int off = WIDTH; off >= 1; off--) begin
            j = (int'(last) + off) % WIDTH;
            if (req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Debounce pacing and switch-change event scheduler. Emits a periodic
// one-cycle debounce_clk enable, detects level changes on the debounced
// switches, and delivers them one at a time as {index, level} events.
//
// Handshake: evt_valid, evt_idx and evt_level are registered and held stable
// while evt_valid=1; an event is consumed on a rising clk edge where
// evt_valid & evt_ready. evt_ready never combinationally affects evt_valid.
module switch_event_arbiter
    import swt_pkg::*;
#(
    parameter  int WIDTH    = SWT_W,
    parameter  int TICK_DIV = TICK_DIV_DEFAULT,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             debounce_clk,
    input  logic [WIDTH-1:0] de_swt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_level,
    output logic [WIDTH-1:0] pend,
    output logic             overrun
);

    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] RR_INIT   = IDX_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             overrun_q, overrun_d;
    state_e           state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    logic             evt_level_q, evt_level_d;
    logic [IDX_W-1:0] rr_last_q, rr_last_d;

    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] clr;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(
        .WIDTH (WIDTH)
    ) u_picker (
        .req  (pend_q),
        .last (rr_last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Tick divider: pulse is registered, so it appears the cycle after the last count.
    always_comb begin
        tick_d = (cnt_q == TICK_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    // Change detection, grant, pending-request and overrun bookkeeping.
    always_comb begin
        chg         = de_swt ^ prev_q;
        prev_d      = de_swt;
        clr         = '0;
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        evt_level_d = evt_level_q;
        rr_last_d   = rr_last_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    clr[pick_idx] = 1'b1;
                    evt_idx_d     = pick_idx;
                    evt_level_d   = de_swt[pick_idx];
                    rr_last_d     = pick_idx;
                    evt_valid_d   = 1'b1;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // A fresh change on the bit being granted keeps it pending.
        pend_d    = chg | (pend_q & ~clr);
        overrun_d = overrun_q | (|(chg & pend_q & ~clr));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            prev_q      <= '0;
            pend_q      <= '0;
            overrun_q   <= 1'b0;
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            evt_level_q <= 1'b0;
            rr_last_q   <= RR_INIT;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            evt_level_q <= evt_level_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign debounce_clk = tick_q;
    assign evt_valid    = evt_valid_q;
    assign evt_idx      = evt_idx_q;
    assign evt_level    = evt_level_q;
    assign pend         = pend_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Bench for switch_event_arbiter with TICK_DIV=4, WIDTH=8. Directed stimulus
// pushes expected {idx, level} events into exp_q; a negedge monitor pops and
// compares on every accepted handshake.
module tb_switch_event_arbiter;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int IDX_W    = 3;

    logic             clk;
    logic             rst;
    logic             debounce_clk;
    logic [WIDTH-1:0] de_swt;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_level;
    logic [WIDTH-1:0] pend;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [IDX_W:0] exp_q[$];
    logic [IDX_W:0] mon_exp;

    switch_event_arbiter #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .debounce_clk (debounce_clk),
        .de_swt       (de_swt),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_idx      (evt_idx),
        .evt_level    (evt_level),
        .pend         (pend),
        .overrun      (overrun)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        de_swt = '0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic push_evt(input int idx, input logic lvl);
        exp_q.push_back({IDX_W'(idx), lvl});
    endtask

    // Wait for all expected events to be consumed and the arbiter to go idle.
    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || evt_valid || pend != '0) && k < 60) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= 60) begin
            n_err++;
            $display("FAIL %s_drain_timeout: got %0d cycles, queue %0d left, required idle within 60",
                     name, k, exp_q.size());
        end
    endtask

    // Scoreboard monitor: every accepted event must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got idx=%0d level=%0d, required none", evt_idx, evt_level);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({evt_idx, evt_level} !== mon_exp) begin
                    n_err++;
                    $display("FAIL event: got idx=%0d level=%0d, required idx=%0d level=%0d",
                             evt_idx, evt_level, mon_exp[IDX_W:1], mon_exp[0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        de_swt    = '0;
        evt_ready = 1'b0;

        // 1: reset state and tick period
        do_reset(2);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_idx", 32'(evt_idx), 0);
        check("rst_evt_level", 32'(evt_level), 0);
        check("rst_pend", 32'(pend), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_debounce_clk", 32'(debounce_clk), 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tick_%0d", k), 32'(debounce_clk), (k % 4 == 0) ? 1 : 0);
        end

        // 2: single switch change, two-edge latency
        evt_ready = 1'b1;
        de_swt    = 8'h04;
        step();
        check("t2_valid_after_1", 32'(evt_valid), 0);
        check("t2_pend_after_1", 32'(pend), 32'h04);
        push_evt(2, 1'b1);
        step();
        check("t2_valid_after_2", 32'(evt_valid), 1);
        check("t2_idx", 32'(evt_idx), 2);
        check("t2_level", 32'(evt_level), 1);
        check("t2_pend_cleared", 32'(pend), 0);
        step();
        check("t2_single_event", 32'(evt_valid), 0);
        drain("t2");
        check("t2_pend_final", 32'(pend), 0);

        // 3: two simultaneous changes, round-robin order with wrap-around
        do_reset(1);
        evt_ready = 1'b1;
        de_swt    = 8'h81;
        push_evt(0, 1'b1);
        push_evt(7, 1'b1);
        drain("t3a");
        de_swt = 8'h00;
        push_evt(0, 1'b0);
        push_evt(7, 1'b0);
        drain("t3b");

        // 4: stall in OFFER, overrun on a pending bit
        evt_ready = 1'b0;
        de_swt    = 8'h01;
        step();
        step();
        push_evt(0, 1'b1);
        push_evt(3, 1'b0);
        de_swt = 8'h09;
        step();
        check("t4_pend3", 32'(pend), 32'h08);
        check("t4_no_overrun_yet", 32'(overrun), 0);
        de_swt = 8'h01;
        step();
        check("t4_overrun_set", 32'(overrun), 1);
        check("t4_pend3_kept", 32'(pend), 32'h08);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t4_hold_valid_%0d", k), 32'(evt_valid), 1);
            check($sformatf("t4_hold_idx_%0d", k), 32'(evt_idx), 0);
            check($sformatf("t4_hold_level_%0d", k), 32'(evt_level), 1);
        end
        evt_ready = 1'b1;
        drain("t4");
        check("t4_overrun_sticky", 32'(overrun), 1);

        // 5: change on the bit being granted keeps it pending, no overrun
        do_reset(1);
        check("t5_overrun_reset", 32'(overrun), 0);
        evt_ready = 1'b1;
        de_swt    = 8'h20;
        step();
        de_swt = 8'h00;
        push_evt(5, 1'b0);
        push_evt(5, 1'b0);
        step();
        check("t5_valid", 32'(evt_valid), 1);
        check("t5_idx", 32'(evt_idx), 5);
        check("t5_pend_kept", 32'(pend), 32'h20);
        drain("t5");
        check("t5_no_overrun", 32'(overrun), 0);

        // 6: reset during OFFER clears everything
        evt_ready = 1'b0;
        de_swt    = 8'h02;
        step();
        step();
        check("t6_offer_valid", 32'(evt_valid), 1);
        check("t6_offer_idx", 32'(evt_idx), 1);
        de_swt = 8'h06;
        step();
        de_swt = 8'h02;
        step();
        check("t6_overrun_before", 32'(overrun), 1);
        rst    = 1'b1;
        de_swt = 8'h00;
        step();
        rst = 1'b0;
        check("t6_valid_cleared", 32'(evt_valid), 0);
        check("t6_pend_cleared", 32'(pend), 0);
        check("t6_overrun_cleared", 32'(overrun), 0);
        check("t6_idx_cleared", 32'(evt_idx), 0);
        check("t6_tick_cleared", 32'(debounce_clk), 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t6_tick_%0d", k), 32'(debounce_clk), (k % 4 == 0) ? 1 : 0);
        end

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
